// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage drives the address and the memory answers combinationally.
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID pipeline register of the 5-stage RISC-V pipeline.
// Holds the PC, drives the instruction-memory address, and latches the
// fetched instruction for decode. A redirect from E beats a fetch stall, and
// a flush or redirect beats a decode stall. Counts redirects since reset.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pc_src_E,
  input  logic [XLEN-1:0]  pc_target_E,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  instr_D,
  output logic [XLEN-1:0]  pc_D,
  output logic [XLEN-1:0]  pc_plus4_D,
  output logic             valid_D,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] target_aligned;

  // Sequential PC increment wraps naturally at 2^XLEN; redirect targets are
  // forced word-aligned by clearing their low two bits.
  assign pc_plus4_f     = pc_f + XLEN'(4);
  assign target_aligned = pc_target_E & ~XLEN'(3);
  assign imem.imem_addr = pc_f;

  // PC register: reset, then redirect (even under stall), then stall hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f <= RESET_PC;
    end else if (pc_src_E) begin
      pc_f <= target_aligned;
    end else if (!stallF) begin
      pc_f <= pc_plus4_f;
    end
  end

  // IF/ID register: bubble on reset, flush or redirect; hold on decode stall.
  always_ff @(posedge clk) begin
    if (!rst_n || flushD || pc_src_E) begin
      instr_D    <= NOP_INSTR;
      pc_D       <= '0;
      pc_plus4_D <= '0;
      valid_D    <= 1'b0;
    end else if (!stallD) begin
      instr_D    <= imem.imem_rdata;
      pc_D       <= pc_f;
      pc_plus4_D <= pc_plus4_f;
      valid_D    <= 1'b1;
    end
  end

  // Redirect counter: one per redirect edge, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (pc_src_E && (redirect_cnt != '1)) begin
      redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RISC-V pipeline.
- Holds the PC and drives the instruction-memory address. Latches the fetched instruction into the decode stage.
- Obeys stallF/stallD from the hazard unit, and flushD/redirect from the branch-resolution logic in E.
- Directly upstream of decode, which produces the rs1_D/rs2_D fields that the hazard unit checks.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected into D on reset or flush.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous active-low reset.
- stallF, input, 1, hold the PC this cycle.
- stallD, input, 1, hold the IF/ID register this cycle.
- flushD, input, 1, replace the IF/ID contents with a bubble.
- pc_src_E, input, 1, redirect request from E (taken branch or jump).
- pc_target_E, input, XLEN, redirect target address.
- imem_addr, output, XLEN, instruction-memory address; equals pcF.
- imem_rdata, input, XLEN, combinational instruction-memory read data for imem_addr.
- instr_D, output, XLEN, instruction presented to decode.
- pc_D, output, XLEN, PC of instr_D.
- pc_plus4_D, output, XLEN, pc_D + 4.
- valid_D, output, 1, 1 = instr_D is a real fetched instruction; 0 = bubble.
- redirect_cnt, output, CNT_W, number of redirects taken since reset; saturating.

Behaviour:
- Reset: synchronous, sampled on the rising clk edge while rst_n=0. Reset wins over every other input.
  - pcF = RESET_PC.
  - instr_D = NOP_INSTR, pc_D = 0, pc_plus4_D = 0, valid_D = 0.
  - redirect_cnt = 0.
  - Reset asserted mid-operation discards any in-flight stall or redirect.
- imem_addr = pcF, combinationally. imem_rdata is valid in the same cycle; no wait states.
- Next PC:
  - pc_next = pc_src_E ? {pc_target_E[XLEN-1:2], 2'b00} : pcF + 4.
  - The target's low two bits are forced to zero.
  - pcF + 4 wraps modulo 2^XLEN, so 32'hFFFF_FFFC goes to 32'h0000_0000 with no flag.
- PC register update priority:
  1. rst_n=0.
  2. pc_src_E=1: load the target, even when stallF=1. A redirect overrides a stall.
  3. stallF=1: hold pcF.
  4. Otherwise: load pcF + 4.
- IF/ID register update priority:
  1. rst_n=0.
  2. flushD=1 or pc_src_E=1: load the bubble (instr_D = NOP_INSTR, valid_D = 0, pc_D and pc_plus4_D = 0). Flush overrides stallD.
  3. stallD=1: hold all D outputs, including valid_D.
  4. Otherwise: instr_D = imem_rdata, pc_D = pcF, pc_plus4_D = pcF + 4 (wrapping), valid_D = 1.
- Latency: the instruction at address A is driven on imem_addr in cycle n and appears on instr_D after the edge ending cycle n (one cycle), provided there is no stall or flush.
- redirect_cnt:
  - Increments by 1 on each clock edge with pc_src_E=1 and rst_n=1.
  - Saturates at all-ones; never wraps.
- Stall mismatch: stallF=1 with stallD=0 is legal. The PC holds while D re-latches the same imem_rdata, which duplicates the instruction. Producing this case is the hazard unit's responsibility; this block does not detect it.
- No combinational path from any input to any output except imem_addr (from pcF).

Test Plan:
- Reset then free-run: rst_n=0 for 2 cycles, then 1 with imem returning 32'h00A0_0093 at addr 0 → after reset instr_D=NOP_INSTR, valid_D=0; the first edge after release gives instr_D=32'h00A0_0093, pc_D=0, pc_plus4_D=4, valid_D=1; imem_addr steps 0,4,8,C.
- Load-use stall: at pcF=0x10 assert stallF=stallD=1 for one cycle → pcF stays 0x10, D outputs hold their prior values (pc_D=0x0C), then fetch resumes at 0x14.
- Redirect: pc_src_E=1, pc_target_E=0x0000_0103 at pcF=0x20 → next pcF=0x100, instr_D=NOP_INSTR, valid_D=0, redirect_cnt increments by 1; the following edge gives pc_D=0x100.
- Redirect during stall: stallF=stallD=pc_src_E=1, target 0x200 → pcF=0x200 and D holds a bubble (redirect and flush win over stall).
- Wrap-around: reset with RESET_PC=32'hFFFF_FFFC and free-run → imem_addr goes 0xFFFF_FFFC then 0x0; pc_plus4_D=0 for the first instruction.
- Counter saturation: with CNT_W=4, issue 20 consecutive redirects → redirect_cnt reaches 4'hF and stays there; a mid-run rst_n=0 clears it to 0.
